// File: rtl/frame_buf_writer.sv
// Write side of the ping-pong binary frame buffer: turns a sop/eop framed 1-bit pixel
// stream into registered RAM writes. Optional error counter: FRAME_BUF_WRITER_ERR_CNT_EN.
module frame_buf_writer #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 200,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic              rd_end,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              wr_en,
  output logic              wr_end,
`ifdef FRAME_BUF_WRITER_ERR_CNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              wr_addr_sel
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);

  if (TOTAL > (2 ** ADDR_W)) begin : g_size_check
    $error("frame_buf_writer: IMG_W*IMG_H does not fit in ADDR_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_FULL
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_end_q, wr_end_d;
  logic              wr_sel_q, wr_sel_d;
  logic              err_evt;
  logic              at_last;

  assign at_last = (cnt_q == LAST_IDX);

  // State register and all registered outputs. wr_addr_sel is reset too, because
  // the reader is reset together with the writer and both must agree on the half.
  // NOTE: sequential state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_end_q  <= 1'b0;
      wr_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      wr_end_q  <= wr_end_d;
      wr_sel_q  <= wr_sel_d;
    end
  end

  // Next-state logic. A sop in WRITE restarts the frame and takes priority over eop.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (din_vld && din_sop) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (din_vld) begin
          if (din_sop)      state_d = S_WRITE;
          else if (din_eop) state_d = at_last ? S_FULL : S_IDLE;
          else if (at_last) state_d = S_IDLE;
        end
      end
      S_FULL: begin
        if (rd_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. Address and data hold when no write is issued.
  always_comb begin
    cnt_d     = cnt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    wr_end_d  = wr_end_q;
    wr_sel_d  = wr_sel_q;
    err_evt   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (din_vld && din_sop) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = din;
          cnt_d     = ADDR_W'(1);
        end
      end
      S_WRITE: begin
        if (din_vld) begin
          if (din_sop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = din;
            cnt_d     = ADDR_W'(1);
            err_evt   = 1'b1;
          end else if (din_eop) begin
            if (at_last) begin
              wr_en_d   = 1'b1;
              wr_addr_d = cnt_q;
              wr_data_d = din;
              wr_end_d  = 1'b1;
            end else begin
              cnt_d   = '0;
              err_evt = 1'b1;
            end
          end else if (at_last) begin
            cnt_d   = '0;
            err_evt = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = din;
            cnt_d     = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_FULL: begin
        // Swap on the same wr_end && rd_end condition the reader uses.
        wr_end_d = 1'b1;
        if (rd_end) begin
          wr_sel_d = ~wr_sel_q;
          wr_end_d = 1'b0;
          cnt_d    = '0;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

`ifdef FRAME_BUF_WRITER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (err_evt && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_evt;
  assign unused_err_evt = err_evt;
`endif

  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_en       = wr_en_q;
  assign wr_end      = wr_end_q;
  assign wr_addr_sel = wr_sel_q;

endmodule

// File: tb/tb_frame_buf_writer.sv
// Directed self-checking bench for frame_buf_writer with a tiny 4x2 frame (TOTAL=8).
module tb_frame_buf_writer;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              din = 1'b0;
  logic              din_vld = 1'b0;
  logic              din_sop = 1'b0;
  logic              din_eop = 1'b0;
  logic              rd_end = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              wr_en;
  logic              wr_end;
  logic              wr_addr_sel;
`ifdef FRAME_BUF_WRITER_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;

  logic [ADDR_W-1:0] log_addr[$];
  logic              log_data[$];

  frame_buf_writer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_vld    (din_vld),
    .din_sop    (din_sop),
    .din_eop    (din_eop),
    .rd_end     (rd_end),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .wr_end     (wr_end),
`ifdef FRAME_BUF_WRITER_ERR_CNT_EN
    .err_cnt    (err_cnt),
`endif
    .wr_addr_sel(wr_addr_sel)
  );

  always #5 clk = ~clk;

  // Write log, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic beat(input logic vld, input logic d, input logic sop, input logic eop,
                      input logic rd);
    din_vld = vld;
    din     = d;
    din_sop = sop;
    din_eop = eop;
    rd_end  = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_log();
    idle(1);
    log_addr.delete();
    log_data.delete();
  endtask

  // Sends n beats of pix with sop on beat 0; eop on beat n-1 when with_eop.
  task automatic send(input logic [7:0] pix, input int n, input logic with_eop,
                      input logic rd_on_last);
    for (int i = 0; i < n; i++) begin
      beat(1'b1, pix[i], (i == 0), with_eop && (i == n - 1), rd_on_last && (i == n - 1));
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({wr_addr, wr_data, wr_en, wr_end, wr_addr_sel} !== '0) begin
      n_bad++;
      $display("FAIL reset_in: addr=%0h data=%b en=%b end=%b sel=%b want all 0",
               wr_addr, wr_data, wr_en, wr_end, wr_addr_sel);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    n_cmp++;
    if ({wr_addr, wr_data, wr_en, wr_end, wr_addr_sel} !== '0) begin
      n_bad++;
      $display("FAIL reset_out: addr=%0h data=%b en=%b end=%b sel=%b want all 0",
               wr_addr, wr_data, wr_en, wr_end, wr_addr_sel);
    end
`ifdef FRAME_BUF_WRITER_ERR_CNT_EN
    n_cmp++;
    if (err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
    end
`endif
  endtask

  task automatic test_clean_frame();
    logic [7:0] pix;
    pix = 8'b0100_1101;
    clear_log();
    send(pix, 7, 1'b0, 1'b0);
    n_cmp++;
    if (wr_end !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_end_early: wr_end=%b want 0", wr_end);
    end
    beat(1'b1, pix[7], 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (wr_end !== 1'b1) begin
      n_bad++;
      $display("FAIL clean_end: wr_end=%b want 1 one cycle after eop", wr_end);
    end
    idle(1);
    n_cmp++;
    if (log_addr.size() !== 8) begin
      n_bad++;
      $display("FAIL clean_count: %0d writes want 8", log_addr.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== pix[i]) begin
          n_bad++;
          $display("FAIL clean_write[%0d]: addr=%0d data=%b want addr=%0d data=%b",
                   i, log_addr[i], log_data[i], i, pix[i]);
        end
      end
    end
    n_cmp++;
    if (wr_addr_sel !== 1'b0 || wr_en !== 1'b0) begin
      n_bad++;
      $display("FAIL clean_sel: sel=%b en=%b want sel=0 en=0", wr_addr_sel, wr_en);
    end
  endtask

  task automatic test_full_drop();
    clear_log();
    send(8'b1111_1111, 8, 1'b1, 1'b0);
    idle(1);
    n_cmp++;
    if (log_addr.size() !== 0) begin
      n_bad++;
      $display("FAIL full_drop_count: %0d writes want 0", log_addr.size());
    end
    n_cmp++;
    if (wr_addr !== ADDR_W'(7) || wr_end !== 1'b1) begin
      n_bad++;
      $display("FAIL full_drop_hold: addr=%0d end=%b want addr=7 end=1", wr_addr, wr_end);
    end
  endtask

  task automatic test_swap();
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (wr_addr_sel !== 1'b1 || wr_end !== 1'b0) begin
      n_bad++;
      $display("FAIL swap1: sel=%b end=%b want sel=1 end=0", wr_addr_sel, wr_end);
    end
    // rd_end coincident with the eop beat must not swap.
    clear_log();
    send(8'b0011_1100, 8, 1'b1, 1'b1);
    n_cmp++;
    if (wr_end !== 1'b1 || wr_addr_sel !== 1'b1) begin
      n_bad++;
      $display("FAIL swap_completion_rd: end=%b sel=%b want end=1 sel=1", wr_end, wr_addr_sel);
    end
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (wr_addr_sel !== 1'b0 || wr_end !== 1'b0) begin
      n_bad++;
      $display("FAIL swap2: sel=%b end=%b want sel=0 end=0", wr_addr_sel, wr_end);
    end
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (wr_addr_sel !== 1'b0) begin
      n_bad++;
      $display("FAIL swap_idle_rd: sel=%b want 0", wr_addr_sel);
    end
    // A sop in the swap cycle is dropped; following non-sop beats are ignored in IDLE.
    send(8'b1010_1010, 8, 1'b1, 1'b0);
    clear_log();
    beat(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_cmp++;
    if (log_addr.size() !== 0 || wr_addr_sel !== 1'b1) begin
      n_bad++;
      $display("FAIL swap_sop_drop: writes=%0d sel=%b want writes=0 sel=1",
               log_addr.size(), wr_addr_sel);
    end
  endtask

  task automatic test_short_frame();
    logic [7:0] pix;
    pix = 8'b0001_0110;
    clear_log();
    send(pix, 6, 1'b1, 1'b0);
    exp_err++;
    beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_cmp++;
    if (log_addr.size() !== 5 || wr_end !== 1'b0 || wr_addr !== ADDR_W'(4)) begin
      n_bad++;
      $display("FAIL short_frame: writes=%0d end=%b addr=%0d want writes=5 end=0 addr=4",
               log_addr.size(), wr_end, wr_addr);
    end
`ifdef FRAME_BUF_WRITER_ERR_CNT_EN
    n_cmp++;
    if (err_cnt !== 8'(exp_err)) begin
      n_bad++;
      $display("FAIL short_err_cnt: got %0d want %0d", err_cnt, exp_err);
    end
`endif
    pix = 8'b1110_0101;
    clear_log();
    send(pix, 8, 1'b1, 1'b0);
    idle(1);
    n_cmp++;
    if (log_addr.size() !== 8 || wr_end !== 1'b1) begin
      n_bad++;
      $display("FAIL short_recover: writes=%0d end=%b want writes=8 end=1",
               log_addr.size(), wr_end);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== pix[i]) begin
          n_bad++;
          $display("FAIL short_recover[%0d]: addr=%0d data=%b want addr=%0d data=%b",
                   i, log_addr[i], log_data[i], i, pix[i]);
        end
      end
    end
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_mid_sop();
    logic [7:0] pa;
    logic [7:0] pb;
    logic [ADDR_W-1:0] ea;
    logic ed;
    pa = 8'b0000_0101;
    pb = 8'b1001_0011;
    clear_log();
    send(pa, 3, 1'b0, 1'b0);
    send(pb, 8, 1'b1, 1'b0);
    exp_err++;
    idle(1);
    n_cmp++;
    if (log_addr.size() !== 11 || wr_end !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_sop: writes=%0d end=%b want writes=11 end=1",
               log_addr.size(), wr_end);
    end else begin
      for (int i = 0; i < 11; i++) begin
        ea = (i < 3) ? ADDR_W'(i) : ADDR_W'(i - 3);
        ed = (i < 3) ? pa[i] : pb[i-3];
        n_cmp++;
        if (log_addr[i] !== ea || log_data[i] !== ed) begin
          n_bad++;
          $display("FAIL mid_sop[%0d]: addr=%0d data=%b want addr=%0d data=%b",
                   i, log_addr[i], log_data[i], ea, ed);
        end
      end
    end
`ifdef FRAME_BUF_WRITER_ERR_CNT_EN
    n_cmp++;
    if (err_cnt !== 8'(exp_err)) begin
      n_bad++;
      $display("FAIL mid_sop_err_cnt: got %0d want %0d", err_cnt, exp_err);
    end
`endif
    beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (wr_addr_sel !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_sop_swap: sel=%b want 1", wr_addr_sel);
    end
  endtask

  task automatic test_long_frame();
    clear_log();
    send(8'b1111_1111, 8, 1'b0, 1'b0);
    exp_err++;
    beat(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    n_cmp++;
    if (log_addr.size() !== 7 || wr_end !== 1'b0 || wr_addr !== ADDR_W'(6)) begin
      n_bad++;
      $display("FAIL long_frame: writes=%0d end=%b addr=%0d want writes=7 end=0 addr=6",
               log_addr.size(), wr_end, wr_addr);
    end
`ifdef FRAME_BUF_WRITER_ERR_CNT_EN
    n_cmp++;
    if (err_cnt !== 8'(exp_err)) begin
      n_bad++;
      $display("FAIL long_err_cnt: got %0d want %0d", err_cnt, exp_err);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [7:0] pix;
    pix = 8'b0110_1001;
    clear_log();
    send(pix, 5, 1'b0, 1'b0);
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(4) || wr_addr_sel !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset: en=%b addr=%0d sel=%b want en=1 addr=4 sel=1",
               wr_en, wr_addr, wr_addr_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_addr, wr_data, wr_en, wr_end, wr_addr_sel} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: addr=%0d data=%b en=%b end=%b sel=%b want all 0",
               wr_addr, wr_data, wr_en, wr_end, wr_addr_sel);
    end
    exp_err = 0;
    din_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    send(pix, 8, 1'b1, 1'b0);
    idle(1);
    n_cmp++;
    if (log_addr.size() !== 8 || wr_end !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset: writes=%0d end=%b want writes=8 end=1",
               log_addr.size(), wr_end);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (log_addr[i] !== ADDR_W'(i) || log_data[i] !== pix[i]) begin
          n_bad++;
          $display("FAIL post_reset[%0d]: addr=%0d data=%b want addr=%0d data=%b",
                   i, log_addr[i], log_data[i], i, pix[i]);
        end
      end
    end
`ifdef FRAME_BUF_WRITER_ERR_CNT_EN
    n_cmp++;
    if (err_cnt !== 8'(exp_err)) begin
      n_bad++;
      $display("FAIL post_reset_err_cnt: got %0d want %0d", err_cnt, exp_err);
    end
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_clean_frame();
    test_full_drop();
    test_swap();
    test_short_frame();
    test_mid_sop();
    test_long_frame();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_buf_writer.md
Name: frame_buf_writer

Overview:
- Write side of the ping-pong binary frame buffer used by the edge-detection display path.
- Accepts the processed 1-bit pixel stream (sop/eop framed, IMG_W x IMG_H, raster order) and emits registered RAM write address, data and enable.
- Raises wr_end when a complete frame is stored. Swaps the buffer half select (wr_addr_sel) in lock-step with the display reader's end-of-frame pulse rd_end.

Parameters:
IMG_W, 320, pixels per line
IMG_H, 200, lines per frame
ADDR_W, 16, write address width; IMG_W*IMG_H must be <= 2**ADDR_W

Ports:
clk  input  1  pixel-domain clock
rst_n  input  1  asynchronous active-low reset
din  input  1  binary pixel (1 = edge/white)
din_vld  input  1  pixel valid
din_sop  input  1  first pixel of frame, qualified by din_vld
din_eop  input  1  last pixel of frame, qualified by din_vld
rd_end  input  1  one-cycle pulse from display reader at end of its frame
wr_addr  output  ADDR_W  RAM write address (pixel index within the half)
wr_data  output  1  RAM write data
wr_en  output  1  RAM write strobe
wr_end  output  1  level: full frame stored, waiting for swap
wr_addr_sel  output  1  buffer half being written; reader uses the opposite half

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All outputs are registered.
- Reset values: wr_addr=0, wr_data=0, wr_en=0, wr_end=0, wr_addr_sel=0. FSM=IDLE, pixel counter cnt=0.
- TOTAL = IMG_W*IMG_H. Counter width is ADDR_W. No wrap-around is ever reached because completion or error fires at index TOTAL-1.
- Latency: a pixel accepted in cycle N appears on wr_addr/wr_data/wr_en in cycle N+1. wr_en is high for exactly one cycle per written pixel.
- FSM IDLE:
  - din_vld without sop is ignored.
  - din_vld&&din_sop: write din at addr 0, cnt<=1, go to WRITE.
- FSM WRITE:
  - din_vld, no sop/eop, cnt<TOTAL-1: write at addr cnt, cnt++.
  - din_vld&&din_eop&&cnt==TOTAL-1: write at addr TOTAL-1, go to FULL. wr_end<=1 in the same registered update, so wr_end is visible 1 cycle after the eop pixel.
  - din_vld&&din_eop&&cnt!=TOTAL-1 (short frame): error. Pixel not written, cnt<=0, go to IDLE.
  - din_vld&&!din_eop&&cnt==TOTAL-1 (long frame): error. Pixel not written, go to IDLE.
  - din_vld&&din_sop (sop mid-frame; overrides eop if both are set): error, then restart. Write din at addr 0, cnt<=1, stay in WRITE.
  - Gaps (din_vld=0) are allowed anywhere. No timeout.
- FSM FULL:
  - wr_end=1. All din_vld beats are dropped (no wr_en), including sop.
  - rd_end=1: wr_addr_sel<=~wr_addr_sel, wr_end<=0, go to IDLE. A sop arriving in that same cycle is dropped; capture restarts on the next sop.
- rd_end outside FULL is ignored. rd_end in the completion cycle itself (wr_end not yet high) is ignored, so the swap waits for the next rd_end.
- wr_addr_sel toggles only on wr_end&&rd_end. This is the same condition the reader uses, so both sides flip in the same cycle.
- wr_addr holds its last value when wr_en=0.
- Reset asserted mid-frame: all state returns to reset values immediately. A partial frame is abandoned, and wr_addr_sel returns to 0 (the reader resets together with the writer).

Optional Feature:
- Macro FRAME_BUF_WRITER_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments by 1 on each short-frame, long-frame or mid-frame-sop error event.
  - Saturates at 255.
  - Dropped beats in FULL or IDLE are not counted.
- When undefined: no err_cnt port and no counter logic. Behaviour is otherwise identical.

Test Plan:
- Single clean frame with IMG_W=4, IMG_H=2 (TOTAL=8), pixels 1,0,1,1,0,0,1,0 back-to-back:
  - wr_en pulses 8 times, addr 0..7 with matching data.
  - wr_end=1 one cycle after eop.
  - wr_addr_sel stays 0 until rd_end.
- Swap: after the test 1 frame, pulse rd_end → wr_addr_sel=1 and wr_end=0 the next cycle. A second full frame followed by rd_end → wr_addr_sel=0.
- Frame while FULL: send a complete 8-pixel frame while wr_end=1 → zero wr_en pulses, wr_addr unchanged.
- Short frame (eop at index 5) → no write at index 5, FSM returns to IDLE, wr_end stays 0, err_cnt=1 with macro. A following clean frame is captured from addr 0.
- Mid-frame sop at index 3 → write at addr 0 with the new pixel, subsequent addresses 1,2,…. Frame completes normally with 8 more beats, err_cnt=1.
- Async reset mid-frame at index 4 while wr_addr_sel=1 → all outputs return to reset values immediately, including wr_addr_sel=0. The next sop frame writes from addr 0.
